// File: rtl/op_dispatch.sv
// op_dispatch: accepts one operation request at a time and forwards the
// captured operands to an add/sub, multiply or CORDIC unit. It then waits,
// with a bounded timeout, for that unit's ready and captures its result.
module op_dispatch #(
    parameter int W       = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         ready,
    input  logic [2:0]   operation,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic [W-1:0] data_a,
    output logic [W-1:0] data_b,
    output logic         beg_add_subt,
    output logic         beg_mult,
    output logic         beg_cordic,
    output logic         op_mod_add_subt,
    output logic         op_mod_cordic,
    input  logic         ready_add_subt,
    input  logic         ready_mult,
    input  logic         ready_cordic,
    input  logic [W-1:0] result_add_subt,
    input  logic [W-1:0] result_mult,
    input  logic [W-1:0] result_cordic,
    output logic [W-1:0] result,
    output logic         done,
    output logic         err_op,
    output logic         err_timeout
);

    localparam int              CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   TO_VAL = CW'(TIMEOUT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MULT = 3'b010;
    localparam logic [2:0] OP_COR0 = 3'b011;
    localparam logic [2:0] OP_COR1 = 3'b100;

    logic [1:0]    r_state;
    logic [2:0]    r_op;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_result;
    logic [CW-1:0] r_cnt;
    logic          r_err_op;
    logic          r_err_to;

    logic          w_legal;
    logic          w_sel_add;
    logic          w_sel_mult;
    logic          w_sel_cordic;
    logic          w_sel_ready;
    logic [W-1:0]  w_sel_result;

    assign w_legal = (operation <= OP_COR1);

    // Decode which unit the captured opcode targets
    always_comb begin
        w_sel_add    = 1'b0;
        w_sel_mult   = 1'b0;
        w_sel_cordic = 1'b0;
        case (r_op)
            OP_ADD, OP_SUB:   w_sel_add    = 1'b1;
            OP_MULT:          w_sel_mult   = 1'b1;
            OP_COR0, OP_COR1: w_sel_cordic = 1'b1;
            default:          ;
        endcase
    end

    // Route only the selected unit's handshake and result; others are ignored
    always_comb begin
        w_sel_ready  = 1'b0;
        w_sel_result = '0;
        if (w_sel_add) begin
            w_sel_ready  = ready_add_subt;
            w_sel_result = result_add_subt;
        end else if (w_sel_mult) begin
            w_sel_ready  = ready_mult;
            w_sel_result = result_mult;
        end else if (w_sel_cordic) begin
            w_sel_ready  = ready_cordic;
            w_sel_result = result_cordic;
        end
    end

    // Control FSM with operand capture, timeout counter and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_err_op <= 1'b0;
            r_err_to <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op <= operation;
                        r_a  <= op_a;
                        r_b  <= op_b;
                        if (w_legal) begin
                            r_state <= ISSUE;
                        end else begin
                            r_state  <= DONE;
                            r_err_op <= 1'b1;
                            r_result <= '0;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                    r_cnt   <= '0;
                end
                WAIT: begin
                    // A ready arriving on the final count still completes normally
                    if (w_sel_ready) begin
                        r_state  <= DONE;
                        r_result <= w_sel_result;
                        r_err_to <= 1'b0;
                    end else if (r_cnt == TO_VAL) begin
                        r_state  <= DONE;
                        r_result <= '0;
                        r_err_to <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_err_op <= 1'b0;
                    r_err_to <= 1'b0;
                end
            endcase
        end
    end

    assign ready           = (r_state == IDLE);
    assign done            = (r_state == DONE);
    assign err_op          = done & r_err_op;
    assign err_timeout     = done & r_err_to;
    assign beg_add_subt    = (r_state == ISSUE) & w_sel_add;
    assign beg_mult        = (r_state == ISSUE) & w_sel_mult;
    assign beg_cordic      = (r_state == ISSUE) & w_sel_cordic;
    assign op_mod_add_subt = (r_state != IDLE) & (r_op == OP_SUB);
    assign op_mod_cordic   = (r_state != IDLE) & (r_op == OP_COR1);
    assign data_a          = r_a;
    assign data_b          = r_b;
    assign result          = r_result;

endmodule

// File: tb/tb_op_dispatch.sv
// tb_op_dispatch: table-driven directed vectors for op_dispatch plus
// hand-written sequences for held start and mid-operation reset.
module tb_op_dispatch;

    localparam int W  = 32;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ready;
    logic [2:0]   operation;
    logic [W-1:0] op_a, op_b, data_a, data_b;
    logic         beg_add_subt, beg_mult, beg_cordic;
    logic         op_mod_add_subt, op_mod_cordic;
    logic         ready_add_subt, ready_mult, ready_cordic;
    logic [W-1:0] result_add_subt, result_mult, result_cordic;
    logic [W-1:0] result;
    logic         done, err_op, err_timeout;

    always #5 clk = ~clk;

    op_dispatch #(.W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .operation(operation), .op_a(op_a), .op_b(op_b),
        .data_a(data_a), .data_b(data_b),
        .beg_add_subt(beg_add_subt), .beg_mult(beg_mult), .beg_cordic(beg_cordic),
        .op_mod_add_subt(op_mod_add_subt), .op_mod_cordic(op_mod_cordic),
        .ready_add_subt(ready_add_subt), .ready_mult(ready_mult), .ready_cordic(ready_cordic),
        .result_add_subt(result_add_subt), .result_mult(result_mult), .result_cordic(result_cordic),
        .result(result), .done(done), .err_op(err_op), .err_timeout(err_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // unit: 0 add/sub, 1 mult, 2 cordic, 3 none (illegal op)
    // k: cycle in which the selected unit raises ready (0 = never)
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ures;
        int          k;
        bit          distract;
        int          unit;
        int          exp_done;
        logic [31:0] exp_res;
        bit          exp_eop;
        bit          exp_eto;
        bit          exp_madd;
        bit          exp_mcor;
    } vec_t;

    // Drive unit handshakes for one cycle; distract raises all other units'
    // ready and the selected ready during ISSUE, all of which must be ignored.
    task automatic drive_units(input int unit, input int cyc, input int k,
                               input bit distract, input logic [31:0] ures);
        bit sel;
        sel = (k >= 2 && cyc == k) || (distract && cyc == 1);
        ready_add_subt  = (unit == 0) ? sel : distract;
        ready_mult      = (unit == 1) ? sel : distract;
        ready_cordic    = (unit == 2) ? sel : distract;
        result_add_subt = (unit == 0 && cyc == k) ? ures : 32'hBAD0_0001;
        result_mult     = (unit == 1 && cyc == k) ? ures : 32'hBAD0_0002;
        result_cordic   = (unit == 2 && cyc == k) ? ures : 32'hBAD0_0003;
    endtask

    task automatic clear_units();
        ready_add_subt = 1'b0; ready_mult = 1'b0; ready_cordic = 1'b0;
        result_add_subt = '0;  result_mult = '0;  result_cordic = '0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after DONE
    task automatic run_vec(input vec_t v, input int idx);
        chk($sformatf("v%0d ready_idle", idx), ready, 1);
        start = 1'b1; operation = v.op; op_a = v.a; op_b = v.b;
        clear_units();
        @(negedge clk);
        start = 1'b0; operation = 3'b000; op_a = '1; op_b = '1;
        for (int cyc = 1; cyc <= v.exp_done; cyc++) begin
            chk($sformatf("v%0d c%0d beg_add", idx, cyc), beg_add_subt, (cyc == 1 && v.unit == 0));
            chk($sformatf("v%0d c%0d beg_mult", idx, cyc), beg_mult, (cyc == 1 && v.unit == 1));
            chk($sformatf("v%0d c%0d beg_cordic", idx, cyc), beg_cordic, (cyc == 1 && v.unit == 2));
            chk($sformatf("v%0d c%0d done", idx, cyc), done, (cyc == v.exp_done));
            chk($sformatf("v%0d c%0d ready", idx, cyc), ready, 0);
            chk($sformatf("v%0d c%0d mod_add", idx, cyc), op_mod_add_subt, v.exp_madd);
            chk($sformatf("v%0d c%0d mod_cordic", idx, cyc), op_mod_cordic, v.exp_mcor);
            chk($sformatf("v%0d c%0d data_a", idx, cyc), data_a, v.a);
            chk($sformatf("v%0d c%0d data_b", idx, cyc), data_b, v.b);
            chk($sformatf("v%0d c%0d err_op", idx, cyc), err_op, (cyc == v.exp_done) ? v.exp_eop : 1'b0);
            chk($sformatf("v%0d c%0d err_to", idx, cyc), err_timeout, (cyc == v.exp_done) ? v.exp_eto : 1'b0);
            if (cyc == v.exp_done)
                chk($sformatf("v%0d result", idx), result, v.exp_res);
            drive_units(v.unit, cyc, v.k, v.distract, v.ures);
            @(negedge clk);
        end
        clear_units();
        chk($sformatf("v%0d ready_after", idx), ready, 1);
        chk($sformatf("v%0d done_after", idx), done, 0);
        chk($sformatf("v%0d mod_add_after", idx), op_mod_add_subt, 0);
        chk($sformatf("v%0d mod_cor_after", idx), op_mod_cordic, 0);
        chk($sformatf("v%0d err_after", idx), {err_op, err_timeout}, 0);
        chk($sformatf("v%0d result_held", idx), result, v.exp_res);
    endtask

    vec_t vecs[10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        op      a             b             ures          k  dis un done exp_res      eop eto madd mcor
        vecs[0] = '{3'b000, 32'h3F800000, 32'h40000000, 32'h40400000, 4, 0, 0, 5, 32'h40400000, 0, 0, 0, 0};
        vecs[1] = '{3'b001, 32'h00000010, 32'h00000003, 32'h12345678, 2, 1, 0, 3, 32'h12345678, 0, 0, 1, 0};
        vecs[2] = '{3'b010, 32'h00000007, 32'h00000006, 32'hDEADBEEF, 3, 1, 1, 4, 32'hDEADBEEF, 0, 0, 0, 0};
        vecs[3] = '{3'b110, 32'h11111111, 32'h22222222, 32'h0,        0, 1, 3, 1, 32'h00000000, 1, 0, 0, 0};
        vecs[4] = '{3'b011, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hCAFEF00D, 5, 1, 2, 6, 32'hCAFEF00D, 0, 0, 0, 0};
        vecs[5] = '{3'b100, 32'h00000100, 32'h00000200, 32'h0BADC0DE, 3, 1, 2, 4, 32'h0BADC0DE, 0, 0, 0, 1};
        vecs[6] = '{3'b101, 32'h33333333, 32'h44444444, 32'h0,        0, 0, 3, 1, 32'h00000000, 1, 0, 0, 0};
        vecs[7] = '{3'b010, 32'h00000002, 32'h00000003, 32'h0,        0, 1, 1, 7, 32'h00000000, 0, 1, 0, 0};
        vecs[8] = '{3'b010, 32'h00000004, 32'h00000005, 32'h00000014, 6, 1, 1, 7, 32'h00000014, 0, 0, 0, 0};
        vecs[9] = '{3'b111, 32'h55555555, 32'h66666666, 32'h0,        0, 0, 3, 1, 32'h00000000, 1, 0, 0, 0};

        rst = 1'b0; start = 1'b0; operation = '0; op_a = '0; op_b = '0;
        clear_units();
        repeat (2) @(negedge clk);
        chk("rst ready", ready, 1);
        chk("rst outs", {beg_add_subt, beg_mult, beg_cordic, op_mod_add_subt, op_mod_cordic, done, err_op, err_timeout}, 0);
        chk("rst data_a", data_a, 0);
        chk("rst data_b", data_b, 0);
        chk("rst result", result, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst ready", ready, 1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // start held high: single capture, next capture only back in IDLE
        start = 1'b1; operation = 3'b000; op_a = 32'h1; op_b = 32'h2;
        @(negedge clk);
        op_a = 32'h9; op_b = 32'h9; operation = 3'b001;
        chk("hold c1 beg_add", beg_add_subt, 1);
        chk("hold c1 data_a", data_a, 32'h1);
        @(negedge clk);
        chk("hold c2 beg_add", beg_add_subt, 0);
        chk("hold c2 ready", ready, 0);
        chk("hold c2 data_a", data_a, 32'h1);
        ready_add_subt = 1'b1; result_add_subt = 32'h77;
        @(negedge clk);
        clear_units();
        chk("hold c3 done", done, 1);
        chk("hold c3 result", result, 32'h77);
        chk("hold c3 data_b", data_b, 32'h2);
        op_a = 32'h5; op_b = 32'h6;
        @(negedge clk);
        chk("hold c4 ready", ready, 1);
        chk("hold c4 data_a", data_a, 32'h1);
        @(negedge clk);
        start = 1'b0;
        chk("hold c5 beg_add", beg_add_subt, 1);
        chk("hold c5 mod_add", op_mod_add_subt, 1);
        chk("hold c5 data_a", data_a, 32'h5);
        chk("hold c5 data_b", data_b, 32'h6);
        @(negedge clk);
        ready_add_subt = 1'b1; result_add_subt = 32'h55;
        @(negedge clk);
        clear_units();
        chk("hold c7 done", done, 1);
        chk("hold c7 result", result, 32'h55);
        chk("hold c7 err", {err_op, err_timeout}, 0);
        @(negedge clk);
        chk("hold c8 ready", ready, 1);

        // reset during WAIT aborts, later unit ready is ignored
        start = 1'b1; operation = 3'b100; op_a = 32'hA; op_b = 32'hB;
        @(negedge clk);
        start = 1'b0;
        chk("rstw c1 beg_cordic", beg_cordic, 1);
        repeat (2) @(negedge clk);
        chk("rstw c3 mod_cordic", op_mod_cordic, 1);
        rst = 1'b0;
        #1;
        chk("rstw ready", ready, 1);
        chk("rstw outs", {beg_add_subt, beg_mult, beg_cordic, op_mod_add_subt, op_mod_cordic, done, err_op, err_timeout}, 0);
        chk("rstw data_a", data_a, 0);
        chk("rstw data_b", data_b, 0);
        chk("rstw result", result, 0);
        @(negedge clk);
        rst = 1'b1;
        ready_cordic = 1'b1; result_cordic = 32'hFFFF0000; ready_mult = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rstw after c%0d done", c), done, 0);
            chk($sformatf("rstw after c%0d ready", c), ready, 1);
            chk($sformatf("rstw after c%0d result", c), result, 0);
        end
        clear_units();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/op_dispatch.md
OP_DISPATCH -- requirements
Module: op_dispatch

Interface
REQ-001 SHALL have parameter W, default 32: operand/result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255: max WAIT cycles before abort; counter width $clog2(TIMEOUT+1).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports start  in  1  request valid; ready  out  1  dispatcher accepting.
REQ-006 SHALL have port operation  in  3  opcode: 000 add, 001 sub, 010 mult, 011 cordic mode0, 100 cordic mode1, 101-111 illegal.
REQ-007 SHALL have ports op_a, op_b  in  W  operands; data_a, data_b  out  W  registered operands to units.
REQ-008 SHALL have outputs beg_add_subt, beg_mult, beg_cordic (1 each): unit start pulses; op_mod_add_subt, op_mod_cordic (1 each): unit mode.
REQ-009 SHALL have inputs ready_add_subt, ready_mult, ready_cordic (1 each) and result_add_subt, result_mult, result_cordic (W each).
REQ-010 SHALL have outputs result  W  captured result; done  1  completion pulse; err_op  1  illegal-op flag; err_timeout  1  timeout flag.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-012 ready SHALL be 1 only in IDLE; start with ready=1 SHALL capture operation, op_a, op_b into registers; start with ready=0 SHALL be ignored.
REQ-013 IDLE + accepted legal opcode -> ISSUE; accepted illegal opcode -> DONE with err_op=1, result=0, no beg pulse.
REQ-014 ISSUE SHALL last exactly one cycle, asserting only the selected unit's beg_* for that cycle; -> WAIT.
REQ-015 op_mod_add_subt SHALL be 1 for opcode 001, op_mod_cordic 1 for opcode 100, else 0; both held stable from cycle after capture until return to IDLE.
REQ-016 data_a/data_b SHALL hold captured operands from capture until next capture.
REQ-017 WAIT SHALL sample only the selected unit's ready_*; other units' ready and any ready during ISSUE SHALL be ignored.
REQ-018 WAIT + selected ready=1 -> DONE, capturing the selected unit's result into result.
REQ-019 WAIT counter SHALL clear on entering WAIT and increment each WAIT cycle; at count==TIMEOUT with no ready -> DONE, err_timeout=1, result=0.
REQ-020 Selected ready in same cycle as timeout SHALL win: normal completion, err_timeout=0.
REQ-021 DONE SHALL last one cycle with done=1 -> IDLE; err_op/err_timeout SHALL be valid only with done and clear otherwise.
REQ-022 result SHALL hold its value until the next DONE.
REQ-023 Latency: start accepted cycle 0, beg at cycle 1, unit ready at cycle k>=2 -> done at cycle k+1; illegal op -> done at cycle 1.

Reset
REQ-024 rst=0 SHALL force IDLE immediately; ready=1 after release; beg_*, op_mod_*, done, err_*=0; result, data_a, data_b, counter=0.
REQ-025 Reset mid-operation SHALL abort with no done pulse; later unit ready SHALL be ignored.

Verification
REQ-026 op=000, a=0x3F800000, b=0x40000000, ready_add_subt at cycle 4 with 0x40400000 -> beg_add_subt cycle 1, op_mod_add_subt=0, done cycle 5, result=0x40400000.
REQ-027 op=100 -> beg_cordic one cycle, op_mod_cordic=1 until IDLE; ready_mult=1 during WAIT ignored; ready_cordic completes.
REQ-028 op=110 -> no beg pulse, done+err_op at cycle 1, result=0, ready=1 at cycle 2.
REQ-029 TIMEOUT=4, op=010, no ready_mult -> done+err_timeout after 5 WAIT cycles, result=0; repeat with ready_mult on last WAIT cycle -> normal done, err_timeout=0.
REQ-030 start held high through operation -> only one capture; new capture occurs only after return to IDLE; rst pulsed during WAIT -> no done, ready=1 after release.
